pgm_rom_arbiter: RTL
====================

Name: pgm_rom_arbiter

Overview:
Owns the single port of the 16K x 16-bit AVR program RAM and shares it between two requesters. The bridge-side ROM loader issues byte writes; the CPU issues word fetch requests. Loader bytes are buffered in a small FIFO and merged into the word-wide RAM with byte enables. The block also sequences CPU reset: the CPU is held in reset during a download and released a fixed delay after the download completes and the FIFO has drained.

Parameters:
ADDR_W, 14, word address width of the program RAM (byte address is ADDR_W+1).
FIFO_DEPTH, 4, loader write FIFO entries (power of two, >=2).
RELEASE_DELAY, 16, cycles from load-complete-and-drained to cpu_rst_n rising.

Ports:
clk_74a  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
ld_wr_en  in  1  loader byte-write strobe
ld_wr_addr  in  ADDR_W+1  loader byte address; bit 0 selects the byte lane
ld_wr_data  in  8  loader byte
ld_busy  in  1  download in progress (level)
ld_full  out  1  FIFO full
ld_overflow  out  1  sticky: a push was dropped
cpu_req  in  1  fetch request; held with stable cpu_addr until cpu_ack
cpu_addr  in  ADDR_W  fetch word address
cpu_ack  out  1  one-cycle pulse; cpu_data valid this cycle
cpu_data  out  16  fetched word
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_be  out  2  byte enables; bit 1 = high byte
mem_wdata  out  16  write data
mem_rdata  in  16  RAM read data, 1-cycle synchronous latency
cpu_rst_n  out  1  active-low reset to the CPU core
wr_count  out  16  bytes committed to RAM since the last ld_busy rise; saturates at 16'hFFFF

Behaviour:
- Reset values: every output is 0; the FIFO is empty; FSM is IDLE; the release counter is 0.
- FIFO push: ld_wr_en && (!full || pop this cycle). A push while full with no pop is dropped and sets ld_overflow, which stays set until reset.
- ld_full is registered and equals (count == FIFO_DEPTH).
- FSM states: IDLE, WRITE, READ, READ_WAIT.
- IDLE grant priority:
  - If ld_busy=1 and the FIFO is non-empty, WRITE.
  - Else if the FIFO is full, WRITE.
  - Else if cpu_req=1, READ.
  - Else if the FIFO is non-empty, WRITE.
  - Else stay in IDLE.
- WRITE (1 cycle):
  - Pop the head entry.
  - mem_we=1, mem_addr=addr[ADDR_W:1].
  - mem_be=2'b10 if addr[0]=1, else 2'b01.
  - mem_wdata={data,data}.
  - wr_count++.
  - Next state is IDLE.
- READ: mem_addr=cpu_addr, mem_we=0; next state READ_WAIT.
- READ_WAIT: register mem_rdata into cpu_data, pulse cpu_ack for exactly 1 cycle, return to IDLE.
- Fetch latency: cpu_req seen in IDLE at cycle n gives cpu_ack at n+2. The earliest next grant is n+3. The CPU must drop or change cpu_req at n+3; a held cpu_req is treated as a new request.
- mem_we, mem_be and mem_wdata are 0 outside WRITE. mem_addr holds its last value.
- cpu_data holds its value between acks.
- Reset sequencing:
  - cpu_rst_n drops to 0 in the cycle after ld_busy rises, and the release counter clears.
  - When ld_busy=0 and the FIFO is empty and the FSM is IDLE, the counter increments.
  - When the counter reaches RELEASE_DELAY, cpu_rst_n=1 and the counter holds.
  - ld_busy re-asserting at any point drops cpu_rst_n and clears the counter.
  - After reset_n, cpu_rst_n is released via the same path, i.e. RELEASE_DELAY cycles after reset if idle.
- Fetches while cpu_rst_n=0 are still served, subject to the priority above.
- wr_count clears on the ld_busy rising edge. An edge coinciding with a WRITE yields 1.
- reset_n asserted mid-operation: the FSM aborts immediately; any in-flight ack is lost and FIFO contents are discarded.

Decomposition:
- Package pgm_rom_pkg holds:
  - typedef arb_state_t with the four states;
  - typedef ld_entry_t as a packed {byte addr, data};
  - localparams for the byte-enable codes BE_LO=2'b01 and BE_HI=2'b10.
- One sub-module, pgm_wr_fifo: a parameterised sync FIFO of ld_entry_t with full, empty, count and the same-cycle push+pop-when-full rule.
- The arbiter FSM, release counter and wr_count live in the top module.

Test Plan:
- Reset then idle: after reset_n rises, cpu_rst_n=0 for 16 cycles then 1; all mem_* outputs stay 0.
- Byte merge: ld_busy=1, bytes 0x34@addr0 and 0x12@addr1 give two WRITEs: addr0 be=01 wdata=3434, then addr0 be=10 wdata=1212. A subsequent fetch of word 0 returns 0x1234 with cpu_ack exactly 2 cycles after the grant; wr_count=2.
- Priority: ld_busy=0, 2 FIFO entries, cpu_req pending gives READ first, then the 2 WRITEs. Repeat with ld_busy=1 gives the 2 WRITEs first, then READ.
- Full/overflow: 5 back-to-back pushes with cpu_req held while ld_busy=0:
  - ld_full asserts and WRITE preempts the read.
  - With no pop, the 5th push is dropped and ld_overflow=1 stays sticky.
  - When a pop coincides with the push, nothing is dropped.
- Reload mid-run: with cpu_rst_n=1, assert ld_busy: cpu_rst_n=0 next cycle and wr_count=0. Drop ld_busy with 3 entries queued: release occurs 16 cycles after the last WRITE.
- Async reset mid-read: assert reset_n=0 in READ_WAIT gives no cpu_ack, all outputs 0 immediately, and the FIFO empty.

Source files
------------

// File: rtl/pgm_rom_pkg.sv
// Shared types and constants for the AVR program RAM arbiter.
package pgm_rom_pkg;

    // Word address width of the 16K x 16 program RAM.
    localparam int PGM_ADDR_W = 14;

    // Byte-enable codes; bit 1 selects the high byte of the word.
    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_READ_WAIT
    } arb_state_t;

    // One buffered loader write: byte address (bit 0 = lane) and the byte.
    typedef struct packed {
        logic [PGM_ADDR_W:0] addr;
        logic [7:0]          data;
    } ld_entry_t;

    // Byte enable for the lane chosen by byte-address bit 0.
    function automatic logic [1:0] lane_be(input logic lane_hi);
        return lane_hi ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/pgm_rom_arbiter_if.sv
// Loader, CPU fetch and RAM port signals of the program RAM arbiter.
interface pgm_rom_arbiter_if
    import pgm_rom_pkg::*;
#(
    parameter int ADDR_W = PGM_ADDR_W
);

    logic              ld_wr_en;
    logic [ADDR_W:0]   ld_wr_addr;
    logic [7:0]        ld_wr_data;
    logic              ld_busy;
    logic              ld_full;
    logic              ld_overflow;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic [15:0]       cpu_data;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [1:0]        mem_be;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;

    logic              cpu_rst_n;
    logic [15:0]       wr_count;

    // Arbiter side.
    modport slave (
        input  ld_wr_en, ld_wr_addr, ld_wr_data, ld_busy,
        input  cpu_req, cpu_addr,
        input  mem_rdata,
        output ld_full, ld_overflow,
        output cpu_ack, cpu_data,
        output mem_addr, mem_we, mem_be, mem_wdata,
        output cpu_rst_n, wr_count
    );

    // Requester / RAM side.
    modport master (
        output ld_wr_en, ld_wr_addr, ld_wr_data, ld_busy,
        output cpu_req, cpu_addr,
        output mem_rdata,
        input  ld_full, ld_overflow,
        input  cpu_ack, cpu_data,
        input  mem_addr, mem_we, mem_be, mem_wdata,
        input  cpu_rst_n, wr_count
    );

endinterface

// File: rtl/pgm_wr_fifo.sv
// Small synchronous FIFO buffering loader byte writes until the RAM port is free.
module pgm_wr_fifo
    import pgm_rom_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req,
    input  ld_entry_t        push_data,
    input  logic             pop,
    output ld_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             dropped
);

    localparam int PTR_W = $clog2(DEPTH);

    ld_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign dropped = push_req && full && !do_pop;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards any queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pgm_rom_arbiter.sv
// Shares the single program RAM port between the ROM loader (byte writes via a
// FIFO) and CPU word fetches, and sequences the CPU reset around downloads.
module pgm_rom_arbiter
    import pgm_rom_pkg::*;
#(
    parameter int ADDR_W        = PGM_ADDR_W,
    parameter int FIFO_DEPTH    = 4,
    parameter int RELEASE_DELAY = 16
)
(
    input  logic              clk_74a,
    input  logic              reset_n,
    pgm_rom_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REL_W = $clog2(RELEASE_DELAY + 1);
    localparam logic [REL_W-1:0] REL_MAX = REL_W'(RELEASE_DELAY);

    arb_state_t        state;
    ld_entry_t         push_entry;
    ld_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_dropped;
    logic              fifo_pop;
    logic              grant_write;
    logic              busy_q;
    logic              busy_rise;

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [1:0]        mem_be_q;
    logic [15:0]       mem_wdata_q;
    logic              cpu_ack_q;
    logic [15:0]       cpu_data_q;
    logic              cpu_rst_n_q;
    logic [REL_W-1:0]  rel_cnt;
    logic [15:0]       wr_count_q;
    logic              overflow_q;

    assign push_entry = '{addr: bus.ld_wr_addr, data: bus.ld_wr_data};
    assign fifo_pop   = (state == ST_WRITE);
    assign busy_rise  = bus.ld_busy && !busy_q;

    // Loader work wins while downloading or when the FIFO is full; otherwise
    // a pending fetch goes first and leftover loader bytes fill idle slots.
    assign grant_write = !fifo_empty && (bus.ld_busy || fifo_full || !bus.cpu_req);

    pgm_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_74a),
        .rst_n     (reset_n),
        .push_req  (bus.ld_wr_en),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .dropped   (fifo_dropped)
    );

    // Arbiter FSM driving the RAM port, the fetch ack and the fetched word.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_data_q  <= '0;
        end else begin
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_write) begin
                        state       <= ST_WRITE;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= head.addr[ADDR_W:1];
                        mem_be_q    <= lane_be(head.addr[0]);
                        mem_wdata_q <= {head.data, head.data};
                    end else if (bus.cpu_req) begin
                        state      <= ST_READ;
                        mem_addr_q <= bus.cpu_addr;
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                ST_READ: begin
                    state     <= ST_READ_WAIT;
                    cpu_ack_q <= 1'b1;
                end
                ST_READ_WAIT: begin
                    state      <= ST_IDLE;
                    cpu_data_q <= bus.mem_rdata;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // CPU reset: dropped on each download start, released after a fixed quiet period.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= 1'b0;
            rel_cnt     <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            busy_q <= bus.ld_busy;
            if (busy_rise) begin
                rel_cnt     <= '0;
                cpu_rst_n_q <= 1'b0;
            end else if (rel_cnt == REL_MAX) begin
                cpu_rst_n_q <= 1'b1;
            end else if (!bus.ld_busy && (fifo_count == '0) && (state == ST_IDLE)) begin
                rel_cnt <= rel_cnt + REL_W'(1);
                if (rel_cnt == REL_MAX - REL_W'(1)) begin
                    cpu_rst_n_q <= 1'b1;
                end
            end
        end
    end

    // Saturating count of bytes committed since the current download began.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            wr_count_q <= '0;
        end else if (busy_rise) begin
            wr_count_q <= (state == ST_WRITE) ? 16'd1 : 16'd0;
        end else if ((state == ST_WRITE) && (wr_count_q != 16'hFFFF)) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    // Sticky flag recording that a loader byte was lost to a full FIFO.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (fifo_dropped) begin
            overflow_q <= 1'b1;
        end
    end

    // The RAM word only exists during READ_WAIT, so it is forwarded in the
    // ack cycle and the captured copy holds it between fetches.
    assign bus.cpu_data    = (state == ST_READ_WAIT) ? bus.mem_rdata : cpu_data_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.ld_full     = fifo_full;
    assign bus.ld_overflow = overflow_q;
    assign bus.cpu_rst_n   = cpu_rst_n_q;
    assign bus.wr_count    = wr_count_q;

endmodule
